// File: rtl/game_ctrl_fsm_pkg.sv
// Shared definitions for the game sequencer: state encoding, tuning constants
// and the move-divider helper used by the PLAY step logic.
package game_ctrl_fsm_pkg;

    typedef enum logic [1:0] {
        ST_MENU  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_e;

    localparam int FRAMES_PER_PT = 60;
    localparam int PTS_PER_LEVEL = 10;
    localparam int MAX_LEVEL     = 7;
    localparam int BASE_DIV      = 8;
    localparam int OVER_HOLD     = 30;
    localparam int SCORE_MAX     = 999;

    localparam logic [5:0] FRAME_LAST = 6'(FRAMES_PER_PT - 1);
    localparam logic [3:0] PT_LAST    = 4'(PTS_PER_LEVEL - 1);
    localparam logic [2:0] LEVEL_SAT  = 3'(MAX_LEVEL);
    localparam logic [4:0] HOLD_SAT   = 5'(OVER_HOLD);
    localparam logic [9:0] SCORE_SAT  = 10'(SCORE_MAX);
    localparam logic [1:0] START_SAT  = 2'd3;

    // Frames between move ticks at a given level, floored at one frame.
    function automatic logic [3:0] move_div(input logic [2:0] lvl);
        if (int'(lvl) >= BASE_DIV) begin
            return 4'd1;
        end
        return 4'(BASE_DIV) - {1'b0, lvl};
    endfunction

endpackage

// File: rtl/game_ctrl_fsm_frame_tick_gen.sv
// Two-flop synchroniser for a level from another clock domain; optionally
// turns the synchronised level's falling edge into a one-cycle pulse.
module game_ctrl_fsm_frame_tick_gen #(
    parameter bit EDGE_EN = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic out_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= sig_i;
            sync_q <= meta_q;
        end
    end

    generate
        if (EDGE_EN) begin : g_edge
            logic prev_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    prev_q <= 1'b0;
                end else begin
                    prev_q <= sync_q;
                end
            end

            assign out_o = prev_q & ~sync_q;
        end else begin : g_level
            assign out_o = sync_q;
        end
    endgenerate

endmodule

// File: rtl/game_ctrl_fsm.sv
// MENU/PLAY/PAUSE/OVER sequencer: turns frame syncs into score, level and
// move ticks, and handles difficulty selection and game-over hold-off.
module game_ctrl_fsm
    import game_ctrl_fsm_pkg::*;
(
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_ok,
    input  logic       vga_vs,
    input  logic       collide,
    output logic [1:0] game_state,
    output logic [1:0] start_lvl,
    output logic [2:0] level,
    output logic [9:0] score,
    output logic       move_tick,
    output logic       clear_field
);

    logic frame_tick;
    logic collide_s;

    game_ctrl_fsm_frame_tick_gen #(.EDGE_EN(1'b1)) u_vs_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .sig_i  (vga_vs),
        .out_o  (frame_tick)
    );

    game_ctrl_fsm_frame_tick_gen #(.EDGE_EN(1'b0)) u_collide_sync (
        .clk_i  (sys_clk),
        .rst_ni (sys_rst_n),
        .sig_i  (collide),
        .out_o  (collide_s)
    );

    state_e     state_q;
    logic [1:0] start_lvl_q;
    logic [2:0] level_q;
    logic [9:0] score_q;
    logic [5:0] frame_cnt_q;
    logic [3:0] pt_cnt_q;
    logic [3:0] div_cnt_q;
    logic [4:0] hold_cnt_q;
    logic       move_tick_q;
    logic       clear_field_q;

    logic [3:0] div_last_d;
    logic       frame_wrap_d;
    logic       pt_wrap_d;
    logic       move_due_d;

    // The divider is re-evaluated from the current level on every frame, so a
    // level change only affects the compare that follows it.
    assign div_last_d   = move_div(level_q) - 4'd1;
    assign frame_wrap_d = (frame_cnt_q == FRAME_LAST);
    assign pt_wrap_d    = (pt_cnt_q == PT_LAST);
    assign move_due_d   = (div_cnt_q >= div_last_d);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_MENU;
            start_lvl_q   <= 2'd0;
            level_q       <= 3'd0;
            score_q       <= 10'd0;
            frame_cnt_q   <= 6'd0;
            pt_cnt_q      <= 4'd0;
            div_cnt_q     <= 4'd0;
            hold_cnt_q    <= 5'd0;
            move_tick_q   <= 1'b0;
            clear_field_q <= 1'b0;
        end else begin
            move_tick_q   <= 1'b0;
            clear_field_q <= 1'b0;
            case (state_q)
                ST_MENU: begin
                    if (key_ok) begin
                        state_q       <= ST_PLAY;
                        score_q       <= 10'd0;
                        level_q       <= {1'b0, start_lvl_q};
                        frame_cnt_q   <= 6'd0;
                        pt_cnt_q      <= 4'd0;
                        div_cnt_q     <= 4'd0;
                        clear_field_q <= 1'b1;
                    end else if (key_up && !key_down && start_lvl_q != START_SAT) begin
                        start_lvl_q <= start_lvl_q + 2'd1;
                    end else if (key_down && !key_up && start_lvl_q != 2'd0) begin
                        start_lvl_q <= start_lvl_q - 2'd1;
                    end
                end
                ST_PLAY: begin
                    // A collision wins over everything, including a frame
                    // that would have scored in this same cycle.
                    if (collide_s) begin
                        state_q    <= ST_OVER;
                        hold_cnt_q <= 5'd0;
                    end else if (key_ok) begin
                        state_q <= ST_PAUSE;
                    end else if (frame_tick) begin
                        if (frame_wrap_d) begin
                            frame_cnt_q <= 6'd0;
                            if (score_q != SCORE_SAT) begin
                                score_q <= score_q + 10'd1;
                            end
                            if (pt_wrap_d) begin
                                pt_cnt_q <= 4'd0;
                                if (level_q != LEVEL_SAT) begin
                                    level_q <= level_q + 3'd1;
                                end
                            end else begin
                                pt_cnt_q <= pt_cnt_q + 4'd1;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 6'd1;
                        end
                        if (move_due_d) begin
                            div_cnt_q   <= 4'd0;
                            move_tick_q <= 1'b1;
                        end else begin
                            div_cnt_q <= div_cnt_q + 4'd1;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (key_ok) begin
                        state_q <= ST_PLAY;
                    end
                end
                ST_OVER: begin
                    if (frame_tick && hold_cnt_q != HOLD_SAT) begin
                        hold_cnt_q <= hold_cnt_q + 5'd1;
                    end
                    if (key_ok && hold_cnt_q == HOLD_SAT) begin
                        state_q <= ST_MENU;
                    end
                end
                default: state_q <= ST_MENU;
            endcase
        end
    end

    assign game_state  = state_q;
    assign start_lvl   = start_lvl_q;
    assign level       = level_q;
    assign score       = score_q;
    assign move_tick   = move_tick_q;
    assign clear_field = clear_field_q;

endmodule
